// File: rtl/asfifo_wptr_gen.sv
// Write-side pointer engine of the asynchronous FIFO (write clock domain).
// Keeps the binary write pointer and publishes a registered gray pointer; derives full/level from the synced read pointer.
module asfifo_wptr_gen #(
  parameter int AW        = 4,
  parameter int PIPE_LINE = 0,
  parameter int U_DLY     = 1
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW:0]   rd_gptr_sync,
  output logic [AW-1:0] wr_addr,
  output logic          wr_push,
  output logic [AW:0]   wr_gptr,
  output logic          full,
  output logic [AW:0]   wr_cnt,
  output logic          wr_err
);

  // U_DLY only shapes behavioural timing; this model uses zero-delay assignments throughout.
  localparam int PIPE_N = PIPE_LINE + (0 * U_DLY);

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [AW:0] wbin_r;
  logic [AW:0] wbin_nxt_s;
  logic [AW:0] wgray_nxt_s;
  logic [AW:0] rbin_s;
  logic [AW:0] full_cmp_s;
  logic        push_s;
  logic        full_r;
  logic        err_r;
  logic [AW:0] cnt_r;
  logic [AW:0] gray_r [0:PIPE_N];

  assign push_s = wr_en & ~full_r;

  // Next-pointer arithmetic and read-pointer decode.
  always_comb begin
    wbin_nxt_s  = wbin_r + {{AW{1'b0}}, push_s};
    wgray_nxt_s = bin2gray(wbin_nxt_s);
    rbin_s      = gray2bin(rd_gptr_sync);
    // Full when the write pointer sits one full lap ahead: top two gray bits inverted.
    full_cmp_s  = {~rd_gptr_sync[AW:AW-1], rd_gptr_sync[AW-2:0]};
  end

  // Binary pointer, full flag, level and overflow strobe.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      wbin_r <= {(AW+1){1'b0}};
      full_r <= 1'b0;
      cnt_r  <= {(AW+1){1'b0}};
      err_r  <= 1'b0;
    end else begin
      wbin_r <= wbin_nxt_s;
      full_r <= (wgray_nxt_s == full_cmp_s);
      cnt_r  <= wbin_nxt_s - rbin_s;
      err_r  <= wr_en & full_r;
    end
  end

  // Base gray register always loads the next value, so the output never sees combinational gray.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      gray_r[0] <= {(AW+1){1'b0}};
    end else begin
      gray_r[0] <= wgray_nxt_s;
    end
  end

  for (genvar s = 1; s <= PIPE_N; s++) begin : g_pipe
    // Extra delay stage on the published gray pointer.
    always_ff @(posedge clk_sys) begin
      if (!rst_n) begin
        gray_r[s] <= {(AW+1){1'b0}};
      end else begin
        gray_r[s] <= gray_r[s-1];
      end
    end
  end

  assign wr_addr = wbin_r[AW-1:0];
  assign wr_push = push_s;
  assign wr_gptr = gray_r[PIPE_N];
  assign full    = full_r;
  assign wr_cnt  = cnt_r;
  assign wr_err  = err_r;

endmodule

// File: tb/tb_asfifo_wptr_gen.sv
// Self-checking bench for asfifo_wptr_gen: directed vector table, hand sequences and
// randomized traffic against an occupancy-count model (two instances: PIPE_LINE 0 and 2).
module tb_asfifo_wptr_gen;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic          rst_n;
  logic          wr_en;
  logic [AW:0]   rd_gptr_sync;

  logic [AW-1:0] a_addr, p_addr;
  logic          a_push, p_push;
  logic [AW:0]   a_gptr, p_gptr;
  logic          a_full, p_full;
  logic [AW:0]   a_cnt,  p_cnt;
  logic          a_err,  p_err;

  asfifo_wptr_gen #(.AW(AW), .PIPE_LINE(0), .U_DLY(1)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .wr_en(wr_en), .rd_gptr_sync(rd_gptr_sync),
    .wr_addr(a_addr), .wr_push(a_push), .wr_gptr(a_gptr), .full(a_full),
    .wr_cnt(a_cnt), .wr_err(a_err)
  );

  asfifo_wptr_gen #(.AW(AW), .PIPE_LINE(2), .U_DLY(1)) dut_p (
    .clk_sys(clk_sys), .rst_n(rst_n), .wr_en(wr_en), .rd_gptr_sync(rd_gptr_sync),
    .wr_addr(p_addr), .wr_push(p_push), .wr_gptr(p_gptr), .full(p_full),
    .wr_cnt(p_cnt), .wr_err(p_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: counts of entries written and read, plus gray history for the pipelined copy.
  int          wr_total;
  int          rd_total;
  logic        full_m;
  logic        err_m;
  int          cnt_m;
  logic [AW:0] hist [0:2];

  typedef struct {
    logic        we;
    int          rd;
    int          addr;
    logic [AW:0] gptr;
    logic        full;
    int          cnt;
    logic        err;
  } vec_t;

  vec_t        vec [8];
  logic [AW:0] gseq [8];
  logic [AW:0] prev;

  function automatic logic [AW:0] gray_of(input int n);
    int m;
    logic [AW:0] b;
    m = n % (2 * DEPTH);
    b = m[AW:0];
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    wr_total = 0;
    rd_total = 0;
    full_m   = 1'b0;
    err_m    = 1'b0;
    cnt_m    = 0;
    for (int i = 0; i < 3; i++) hist[i] = '0;
  endtask

  // One clock: check the combinational strobe, advance the model, compare registered outputs.
  task automatic step();
    rd_gptr_sync = gray_of(rd_total);
    @(negedge clk_sys);
    check("wr_push", {31'd0, a_push}, {31'd0, (wr_en && !full_m)});
    check("wr_push_p", {31'd0, p_push}, {31'd0, (wr_en && !full_m)});
    @(posedge clk_sys);
    if (!rst_n) begin
      model_reset();
    end else begin
      err_m = wr_en && full_m;
      if (wr_en && !full_m) wr_total++;
      cnt_m   = wr_total - rd_total;
      full_m  = (cnt_m == DEPTH);
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = gray_of(wr_total);
    end
    #1;
    check("wr_addr", 32'(a_addr), 32'(wr_total % DEPTH));
    check("wr_gptr", 32'(a_gptr), 32'(hist[0]));
    check("full", {31'd0, a_full}, {31'd0, full_m});
    check("wr_cnt", 32'(a_cnt), 32'(cnt_m));
    check("wr_err", {31'd0, a_err}, {31'd0, err_m});
    check("wr_addr_p", 32'(p_addr), 32'(wr_total % DEPTH));
    check("wr_gptr_p", 32'(p_gptr), 32'(hist[2]));
    check("full_p", {31'd0, p_full}, {31'd0, full_m});
    check("wr_cnt_p", 32'(p_cnt), 32'(cnt_m));
    check("wr_err_p", {31'd0, p_err}, {31'd0, err_m});
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    rd_total = 0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    // fill to full, overflow, release by one read, refill
    vec[0] = '{1'b1, 0, 1, 3'b001, 1'b0, 1, 1'b0};
    vec[1] = '{1'b1, 0, 2, 3'b011, 1'b0, 2, 1'b0};
    vec[2] = '{1'b1, 0, 3, 3'b010, 1'b0, 3, 1'b0};
    vec[3] = '{1'b1, 0, 0, 3'b110, 1'b1, 4, 1'b0};
    vec[4] = '{1'b1, 0, 0, 3'b110, 1'b1, 4, 1'b1};
    vec[5] = '{1'b0, 1, 0, 3'b110, 1'b0, 3, 1'b0};
    vec[6] = '{1'b1, 1, 1, 3'b111, 1'b1, 4, 1'b0};
    vec[7] = '{1'b0, 1, 1, 3'b111, 1'b1, 4, 1'b0};
    gseq = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};

    rst_n        = 1'b0;
    wr_en        = 1'b0;
    rd_gptr_sync = '0;
    model_reset();
    repeat (2) @(posedge clk_sys);
    #1;

    // Reset state, then reset held with wr_en high
    check("reset_addr", 32'(a_addr), 32'd0);
    check("reset_gptr", 32'(a_gptr), 32'd0);
    check("reset_full", {31'd0, a_full}, 32'd0);
    check("reset_cnt", 32'(a_cnt), 32'd0);
    check("reset_err", {31'd0, a_err}, 32'd0);
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("rst_hold_addr", 32'(a_addr), 32'd0);
    check("rst_hold_gptr", 32'(p_gptr), 32'd0);

    // Directed vector table
    do_reset();
    for (int i = 0; i < 8; i++) begin
      wr_en    = vec[i].we;
      rd_total = vec[i].rd;
      step();
      check($sformatf("vec%0d_addr", i), 32'(a_addr), 32'(vec[i].addr));
      check($sformatf("vec%0d_gptr", i), 32'(a_gptr), 32'(vec[i].gptr));
      check($sformatf("vec%0d_full", i), {31'd0, a_full}, {31'd0, vec[i].full});
      check($sformatf("vec%0d_cnt", i), 32'(a_cnt), 32'(vec[i].cnt));
      check($sformatf("vec%0d_err", i), {31'd0, a_err}, {31'd0, vec[i].err});
    end

    // Gray sequence with the read side tracking the writer
    do_reset();
    prev = '0;
    for (int k = 0; k < 8; k++) begin
      wr_en = 1'b1;
      step();
      check($sformatf("gseq%0d", k), 32'(a_gptr), 32'(gseq[k]));
      check($sformatf("gseq%0d_onebit", k), $countones(a_gptr ^ prev), 32'd1);
      prev     = a_gptr;
      rd_total = wr_total;
    end

    // Pipelined gray pointer latency
    do_reset();
    wr_en = 1'b1;
    step();
    check("pipe_addr_e1", 32'(p_addr), 32'd1);
    check("pipe_gptr_e1", 32'(p_gptr), 32'd0);
    wr_en = 1'b0;
    step();
    check("pipe_gptr_e2", 32'(p_gptr), 32'd0);
    step();
    check("pipe_gptr_e3", 32'(p_gptr), 32'd1);

    // Reset in the middle of traffic
    do_reset();
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) step();
    rst_n    = 1'b0;
    rd_total = 0;
    step();
    check("midrst_addr", 32'(a_addr), 32'd0);
    check("midrst_gptr_p", 32'(p_gptr), 32'd0);
    check("midrst_cnt", 32'(a_cnt), 32'd0);
    rst_n = 1'b1;
    step();
    check("resume_addr", 32'(a_addr), 32'd1);
    check("resume_gptr", 32'(a_gptr), 32'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      wr_en = ($urandom_range(0, 3) != 0);
      if (!rst_n) begin
        rd_total = 0;
      end else if (rd_total < wr_total && $urandom_range(0, 1) == 1) begin
        rd_total++;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
